instr_fetch_unit: RTL and testbench

// - IF stage of the MIPS pipeline: owns the program counter, drives the instruction-memory address,
//   and latches the returned word into the IF/ID pipeline register.
// - Sits directly upstream of the instruction ROM (async read, same-cycle data). Sits downstream of

---
 rtl/mips_pkg.sv | 27 ++
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit_ifid_reg.sv | 38 +++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: fetch FSM states, the IF/ID record reused by ID, and fetch constants.
package mips_pkg;

    localparam logic [31:0] START_ADDR_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
    localparam int          IMEM_DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    // A fetch address is usable only if word aligned and inside [lo, hi].
    function automatic logic pc_is_bad(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: stall/redirect control in, imem address/data, IF/ID contents and status out.
interface instr_fetch_unit_if;
    logic        IFU_stall;
    logic        IFU_redirect_valid;
    logic [31:0] IFU_redirect_target;
    logic [31:0] IFU_PC;
    logic [31:0] IFU_mem_instr;
    logic [31:0] IFU_ifid_instr;
    logic [31:0] IFU_ifid_pc4;
    logic        IFU_ifid_valid;
    logic        IFU_halted;
    logic [31:0] IFU_fetch_count;

    modport slave (
        input  IFU_stall, IFU_redirect_valid, IFU_redirect_target, IFU_mem_instr,
        output IFU_PC, IFU_ifid_instr, IFU_ifid_pc4, IFU_ifid_valid, IFU_halted, IFU_fetch_count
    );

    modport master (
        output IFU_stall, IFU_redirect_valid, IFU_redirect_target, IFU_mem_instr,
        input  IFU_PC, IFU_ifid_instr, IFU_ifid_pc4, IFU_ifid_valid, IFU_halted, IFU_fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls; bubble has priority over load.
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  ifid_t       d_i,
    input  logic [31:0] bubble_pc4_i,
    output ifid_t       q_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (bubble_i) begin
            ifid_d = '{instr: NOP_WORD, pc4: bubble_pc4_i, valid: 1'b0};
        end else if (load_i) begin
            ifid_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= '{instr: NOP_WORD, pc4: 32'h0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS IF stage: PC, BOOT/RUN/HALT control, fetch range check and accepted-instruction counter.
// Macro IFU_BRANCH_DELAY_SLOT_EN: redirect keeps the in-flight fetch (delay slot) instead of flushing.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] START_ADDR = START_ADDR_DEFAULT,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.slave  bus
);

    localparam logic [31:0] LAST_ADDR = START_ADDR + 32'(4 * (IMEM_DEPTH - 1));

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;

    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] bubble_pc4;
    logic [31:0] pc_plus4;
    logic        pc_bad;
    ifid_t       ifid_in;
    ifid_t       ifid_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_bad   = pc_is_bad(pc_q, START_ADDR, LAST_ADDR);
    assign ifid_in  = '{instr: bus.IFU_mem_instr, pc4: pc_plus4, valid: 1'b1};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        bubble_pc4  = ifid_q.pc4;

        unique case (state_q)
            BOOT: begin
                ifid_bubble = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                // Range check outranks redirect and stall: a bad PC never reaches IF/ID.
                if (pc_bad) begin
                    state_d     = HALT;
                    ifid_bubble = 1'b1;
                end else if (bus.IFU_redirect_valid) begin
                    pc_d = bus.IFU_redirect_target;
`ifdef IFU_BRANCH_DELAY_SLOT_EN
                    ifid_load = !bus.IFU_stall;
`else
                    ifid_bubble = 1'b1;
                    bubble_pc4  = pc_plus4;
`endif
                end else if (!bus.IFU_stall) begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (ifid_load) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= START_ADDR;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk          (clk),
        .rst          (rst),
        .load_i       (ifid_load),
        .bubble_i     (ifid_bubble),
        .d_i          (ifid_in),
        .bubble_pc4_i (bubble_pc4),
        .q_o          (ifid_q)
    );

    assign bus.IFU_PC          = pc_q;
    assign bus.IFU_ifid_instr  = ifid_q.instr;
    assign bus.IFU_ifid_pc4    = ifid_q.pc4;
    assign bus.IFU_ifid_valid  = ifid_q.valid;
    assign bus.IFU_halted      = (state_q == HALT);
    assign bus.IFU_fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a cycle-level behavioural model.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] START = 32'h0040_0000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .START_ADDR (START),
        .IMEM_DEPTH (DEPTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [DEPTH];
    logic [31:0] rd_off;

    always_comb begin
        rd_off = bus.IFU_PC - START;
        if (bus.IFU_PC >= START && rd_off < 32'(4 * DEPTH)) bus.IFU_mem_instr = rom[rd_off[7:2]];
        else                                                  bus.IFU_mem_instr = 32'hDEAD_BEEF;
    end

    // Reference state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_halted, m_boot;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - START;
        if (pc >= START && off < 32'(4 * DEPTH)) return rom[off[7:2]];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic st, input logic rv, input logic [31:0] tg);
        logic is_bad;
        if (r) begin
            m_pc = START; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
            m_halted = 1'b0; m_count = 32'h0; m_boot = 1'b1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (m_boot) begin
            m_instr = NOP; m_valid = 1'b0; m_boot = 1'b0;
        end else begin
            is_bad = (m_pc % 4 != 0) || (m_pc < START) || (m_pc > START + 4 * (DEPTH - 1));
            if (is_bad) begin
                m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0;
            end else if (rv) begin
`ifdef IFU_BRANCH_DELAY_SLOT_EN
                if (!st) begin
                    m_instr = rom_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1; m_count++;
                end
`else
                m_instr = NOP; m_pc4 = m_pc + 4; m_valid = 1'b0;
`endif
                m_pc = tg;
            end else if (!st) begin
                m_instr = rom_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1; m_count++;
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] tg,
                        input string tag);
        rst = r;
        bus.IFU_stall = st;
        bus.IFU_redirect_valid = rv;
        bus.IFU_redirect_target = tg;
        model(r, st, rv, tg);
        @(posedge clk);
        #1;
        chk({tag, ".pc"},     bus.IFU_PC, m_pc);
        chk({tag, ".instr"},  bus.IFU_ifid_instr, m_instr);
        chk({tag, ".valid"},  32'(bus.IFU_ifid_valid), 32'(m_valid));
        chk({tag, ".halted"}, 32'(bus.IFU_halted), 32'(m_halted));
        chk({tag, ".count"},  bus.IFU_fetch_count, m_count);
        if (m_valid || r) chk({tag, ".pc4"}, bus.IFU_ifid_pc4, m_pc4);
    endtask

    initial begin
        logic [31:0] saved;
        logic        r, st, rv;
        logic [31:0] tg;
        int          guard;

        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        for (int i = 0; i < 4; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1;
        bus.IFU_stall = 1'b0;
        bus.IFU_redirect_valid = 1'b0;
        bus.IFU_redirect_target = 32'h0;
        m_boot = 1'b1;

        step(1, 0, 0, 0, "reset");
        chk("reset_pc", bus.IFU_PC, START);
        chk("reset_pc4", bus.IFU_ifid_pc4, 32'h0);
        chk("reset_count", bus.IFU_fetch_count, 32'h0);
        step(0, 1, 1, 32'h0040_0040, "boot");
        chk("boot_pc_holds", bus.IFU_PC, START);

        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "seq");
        chk("seq_pc", bus.IFU_PC, 32'h0040_0010);
        chk("seq_instr", bus.IFU_ifid_instr, 32'hA000_0003);
        chk("seq_pc4", bus.IFU_ifid_pc4, 32'h0040_0010);
        chk("seq_count", bus.IFU_fetch_count, 32'd4);

        step(1, 0, 0, 0, "reset2");
        step(0, 0, 0, 0, "boot2");
        step(0, 0, 0, 0, "pre_stall");
        step(0, 0, 0, 0, "pre_stall");
        saved = bus.IFU_fetch_count;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, "stall");
            chk("stall_pc", bus.IFU_PC, 32'h0040_0008);
            chk("stall_count", bus.IFU_fetch_count, saved);
        end
        step(0, 0, 0, 0, "release");
        chk("release_instr", bus.IFU_ifid_instr, 32'hA000_0002);
        chk("release_pc", bus.IFU_PC, 32'h0040_000C);

        step(0, 1, 1, 32'h0040_0040, "redir_stall");
        chk("redir_stall_pc", bus.IFU_PC, 32'h0040_0040);
`ifdef IFU_BRANCH_DELAY_SLOT_EN
        chk("redir_stall_valid", 32'(bus.IFU_ifid_valid), 32'd1);
`else
        chk("redir_stall_valid", 32'(bus.IFU_ifid_valid), 32'd0);
`endif

        step(0, 0, 1, 32'h0040_0010, "redir_a");
        saved = bus.IFU_fetch_count;
        step(0, 0, 1, 32'h0040_0020, "redir_b");
        chk("redir_b_pc", bus.IFU_PC, 32'h0040_0020);
`ifdef IFU_BRANCH_DELAY_SLOT_EN
        chk("redir_b_instr", bus.IFU_ifid_instr, rom[4]);
        chk("redir_b_count", bus.IFU_fetch_count, saved + 32'd1);
`else
        chk("redir_b_valid", 32'(bus.IFU_ifid_valid), 32'd0);
        chk("redir_b_count", bus.IFU_fetch_count, saved);
`endif

        guard = 0;
        while (m_pc != 32'h0040_0100 && guard < 100) begin
            step(0, 0, 0, 0, "run");
            guard++;
        end
        chk("run_reached_end", bus.IFU_PC, 32'h0040_0100);
        step(0, 0, 0, 0, "halt_edge");
        chk("halt_flag", 32'(bus.IFU_halted), 32'd1);
        chk("halt_pc", bus.IFU_PC, 32'h0040_0100);
        step(0, 0, 1, 32'h0040_0040, "halt_redir");
        step(0, 1, 1, 32'h0040_0000, "halt_redir");
        chk("halt_redir_pc", bus.IFU_PC, 32'h0040_0100);
        step(1, 0, 0, 0, "reset3");
        step(0, 0, 0, 0, "boot3");
        chk("boot3_halted", 32'(bus.IFU_halted), 32'd0);

        step(0, 0, 1, 32'h0040_0006, "misalign");
        chk("misalign_pc", bus.IFU_PC, 32'h0040_0006);
        chk("misalign_not_yet", 32'(bus.IFU_halted), 32'd0);
        saved = bus.IFU_fetch_count;
        step(0, 0, 0, 0, "misalign_halt");
        chk("misalign_halted", 32'(bus.IFU_halted), 32'd1);
        chk("misalign_count", bus.IFU_fetch_count, saved);

        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 9))
                0:       tg = START + 32'(4 * DEPTH);
                1:       tg = START + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'd2;
                default: tg = START + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            step(r, st, rv, tg, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
